// File: rtl/id_pkg.sv
// Shared encodings for the decode-stage operand block: branch conditions,
// bypass-bus layout and immediate-extension ops.
package id_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_EQ   = 3'b001;
  localparam logic [2:0] BR_NE   = 3'b010;
  localparam logic [2:0] BR_GEZ  = 3'b011;
  localparam logic [2:0] BR_GTZ  = 3'b100;
  localparam logic [2:0] BR_LEZ  = 3'b101;
  localparam logic [2:0] BR_LTZ  = 3'b110;

  localparam logic EXTOP_EXT = 1'b0;
  localparam logic EXTOP_LUI = 1'b1;

  localparam int unsigned BusW       = 38;
  localparam int unsigned BusWeBit   = 37;
  localparam int unsigned BusWdMsb   = 36;
  localparam int unsigned BusWdLsb   = 5;
  localparam int unsigned BusRwMsb   = 4;

  // Field order matches the bit positions above: {reg_write, wd, rw}.
  typedef struct packed {
    logic        reg_write;
    logic [31:0] wd;
    logic [4:0]  rw;
  } bypass_t;

endpackage

// File: rtl/operand_fwd_mux.sv
// Single-operand bypass mux: picks MEM, then WB, then GPR read data.
module operand_fwd_mux
  import id_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic [RW-1:0]  idx,
  input  logic [DW-1:0]  rd,
  input  logic [BusW-1:0] mem_back,
  input  logic [BusW-1:0] wb_back,
  input  logic           use_mem_back,
  input  logic           use_wb_back,
  output logic [DW-1:0]  fwd
);

  bypass_t mem_bus;
  bypass_t wb_bus;
  logic    idx_nz;
  logic    mem_hit;
  logic    wb_hit;

  assign mem_bus = bypass_t'(mem_back);
  assign wb_bus  = bypass_t'(wb_back);
  assign idx_nz  = (idx != '0);
  assign mem_hit = use_mem_back && mem_bus.reg_write && (mem_bus.rw == idx) && idx_nz;
  assign wb_hit  = use_wb_back && wb_bus.reg_write && (wb_bus.rw == idx) && idx_nz;

  always_comb begin
    fwd = rd;
    if (mem_hit) begin
      fwd = mem_bus.wd;
    end else if (wb_hit) begin
      fwd = wb_bus.wd;
    end
  end

endmodule

// File: rtl/id_operand_unit.sv
// Decode-stage operand block: immediate extension, MEM/WB bypass and branch
// evaluation, with a registered copy for the ID/EX stage.
module id_operand_unit
  import id_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            flush,
  input  logic [15:0]     imm,
  input  logic            extop,
  input  logic            exsign,
  input  logic [RW-1:0]   rs,
  input  logic [RW-1:0]   rt,
  input  logic [DW-1:0]   rd1,
  input  logic [DW-1:0]   rd2,
  input  logic [BusW-1:0] mem_back,
  input  logic [BusW-1:0] wb_back,
  input  logic            use_mem_back,
  input  logic            use_wb_back,
  input  logic [2:0]      branch_type,
  output logic [DW-1:0]   extb,
  output logic [DW-1:0]   f_rd1,
  output logic [DW-1:0]   f_rd2,
  output logic            branch_avail,
  output logic [DW-1:0]   q_extb,
  output logic [DW-1:0]   q_rd1,
  output logic [DW-1:0]   q_rd2,
  output logic            q_branch
);

  logic [DW-1:0] extb_q, rd1_q, rd2_q;
  logic          branch_q;

  always_comb begin
    extb = {16'h0, imm};
    if (extop == EXTOP_LUI) begin
      extb = {imm, 16'h0};
    end else if (exsign) begin
      extb = {{16{imm[15]}}, imm};
    end
  end

  operand_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rs (
    .idx          (rs),
    .rd           (rd1),
    .mem_back     (mem_back),
    .wb_back      (wb_back),
    .use_mem_back (use_mem_back),
    .use_wb_back  (use_wb_back),
    .fwd          (f_rd1)
  );

  operand_fwd_mux #(.DW(DW), .RW(RW)) u_fwd_rt (
    .idx          (rt),
    .rd           (rd2),
    .mem_back     (mem_back),
    .wb_back      (wb_back),
    .use_mem_back (use_mem_back),
    .use_wb_back  (use_wb_back),
    .fwd          (f_rd2)
  );

  logic rd1_neg, rd1_zero;
  assign rd1_neg  = f_rd1[DW-1];
  assign rd1_zero = (f_rd1 == '0);

  always_comb begin
    branch_avail = 1'b0;
    case (branch_type)
      BR_EQ:   branch_avail = (f_rd1 == f_rd2);
      BR_NE:   branch_avail = (f_rd1 != f_rd2);
      BR_GEZ:  branch_avail = !rd1_neg;
      BR_GTZ:  branch_avail = !rd1_neg && !rd1_zero;
      BR_LEZ:  branch_avail = rd1_neg || rd1_zero;
      BR_LTZ:  branch_avail = rd1_neg;
      default: branch_avail = 1'b0;
    endcase
  end

  // Flush outranks the load enable so a squashed slot never reaches EX.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      extb_q   <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      branch_q <= 1'b0;
    end else if (flush) begin
      extb_q   <= '0;
      rd1_q    <= '0;
      rd2_q    <= '0;
      branch_q <= 1'b0;
    end else if (en) begin
      extb_q   <= extb;
      rd1_q    <= f_rd1;
      rd2_q    <= f_rd2;
      branch_q <= branch_avail;
    end
  end

  assign q_extb   = extb_q;
  assign q_rd1    = rd1_q;
  assign q_rd2    = rd2_q;
  assign q_branch = branch_q;

endmodule

// File: tb/tb_id_operand_unit.sv
// Directed self-checking bench for id_operand_unit.
module tb_id_operand_unit;

  logic        clk, rst, en, flush;
  logic [15:0] imm;
  logic        extop, exsign;
  logic [4:0]  rs, rt;
  logic [31:0] rd1, rd2;
  logic [37:0] mem_back, wb_back;
  logic        use_mem_back, use_wb_back;
  logic [2:0]  branch_type;
  logic [31:0] extb, f_rd1, f_rd2, q_extb, q_rd1, q_rd2;
  logic        branch_avail, q_branch;

  int n_cmp = 0;
  int n_bad = 0;

  id_operand_unit #(.DW(32), .RW(5)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .flush        (flush),
    .imm          (imm),
    .extop        (extop),
    .exsign       (exsign),
    .rs           (rs),
    .rt           (rt),
    .rd1          (rd1),
    .rd2          (rd2),
    .mem_back     (mem_back),
    .wb_back      (wb_back),
    .use_mem_back (use_mem_back),
    .use_wb_back  (use_wb_back),
    .branch_type  (branch_type),
    .extb         (extb),
    .f_rd1        (f_rd1),
    .f_rd2        (f_rd2),
    .branch_avail (branch_avail),
    .q_extb       (q_extb),
    .q_rd1        (q_rd1),
    .q_rd2        (q_rd2),
    .q_branch     (q_branch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    en = 1'b0; flush = 1'b0; imm = 16'h0; extop = 1'b0; exsign = 1'b0;
    rs = 5'd0; rt = 5'd0; rd1 = 32'h0; rd2 = 32'h0;
    mem_back = 38'h0; wb_back = 38'h0; use_mem_back = 1'b0; use_wb_back = 1'b0;
    branch_type = 3'b000;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle_inputs();
    #12;
    n_cmp++; if (q_extb !== 32'h0) begin n_bad++; $display("FAIL reset_q_extb got %h want %h", q_extb, 32'h0); end
    n_cmp++; if (q_rd1 !== 32'h0) begin n_bad++; $display("FAIL reset_q_rd1 got %h want %h", q_rd1, 32'h0); end
    n_cmp++; if (q_rd2 !== 32'h0) begin n_bad++; $display("FAIL reset_q_rd2 got %h want %h", q_rd2, 32'h0); end
    n_cmp++; if (q_branch !== 1'b0) begin n_bad++; $display("FAIL reset_q_branch got %b want 0", q_branch); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_ext();
    logic [31:0] want [3] = '{32'hFFFF8001, 32'h00008001, 32'h80010000};
    logic [1:0]  ctl  [3] = '{2'b01, 2'b00, 2'b10};  // {extop, exsign}
    for (int i = 0; i < 3; i++) begin
      imm = 16'h8001; extop = ctl[i][1]; exsign = ctl[i][0];
      #1;
      n_cmp++;
      if (extb !== want[i]) begin
        n_bad++; $display("FAIL ext_%0d got %h want %h", i, extb, want[i]);
      end
    end
  endtask

  task automatic test_forward();
    rs = 5'd5; rd1 = 32'h11; rt = 5'd6; rd2 = 32'h22;
    mem_back = {1'b1, 32'hAA, 5'd5}; wb_back = {1'b1, 32'hBB, 5'd5};
    use_mem_back = 1'b1; use_wb_back = 1'b1;
    #1;
    n_cmp++; if (f_rd1 !== 32'hAA) begin n_bad++; $display("FAIL fwd_mem_prio got %h want %h", f_rd1, 32'hAA); end
    n_cmp++; if (f_rd2 !== 32'h22) begin n_bad++; $display("FAIL fwd_rt_nomatch got %h want %h", f_rd2, 32'h22); end
    use_mem_back = 1'b0; #1;
    n_cmp++; if (f_rd1 !== 32'hBB) begin n_bad++; $display("FAIL fwd_wb got %h want %h", f_rd1, 32'hBB); end
    use_mem_back = 1'b1; mem_back[37] = 1'b0; wb_back[37] = 1'b0; #1;
    n_cmp++; if (f_rd1 !== 32'h11) begin n_bad++; $display("FAIL fwd_no_we got %h want %h", f_rd1, 32'h11); end
    rs = 5'd0; mem_back = {1'b1, 32'hAA, 5'd0}; wb_back = {1'b1, 32'hBB, 5'd0}; #1;
    n_cmp++; if (f_rd1 !== 32'h11) begin n_bad++; $display("FAIL fwd_r0 got %h want %h", f_rd1, 32'h11); end
    rt = 5'd6; wb_back = {1'b1, 32'hCC, 5'd6}; use_mem_back = 1'b0; #1;
    n_cmp++; if (f_rd2 !== 32'hCC) begin n_bad++; $display("FAIL fwd_rt_wb got %h want %h", f_rd2, 32'hCC); end
    mem_back = 38'h0; wb_back = 38'h0; use_mem_back = 1'b0; use_wb_back = 1'b0;
  endtask

  task automatic test_branch();
    // {rd1, rd2, type, expected}
    logic [31:0] a    [14] = '{7, 7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                               0, 0, 0, 0, 7, 7, 5, 5};
    logic [31:0] b    [14] = '{7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 3, 3};
    logic [2:0]  t    [14] = '{1, 2, 6, 5, 3, 4, 3, 5, 4, 6, 0, 7, 2, 4};
    logic        want [14] = '{1, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1};
    rs = 5'd1; rt = 5'd2;
    for (int i = 0; i < 14; i++) begin
      rd1 = a[i]; rd2 = b[i]; branch_type = t[i];
      #1;
      n_cmp++;
      if (branch_avail !== want[i]) begin
        n_bad++;
        $display("FAIL branch_%0d type=%0d got %b want %b", i, t[i], branch_avail, want[i]);
      end
    end
  endtask

  task automatic test_branch_fwd();
    rs = 5'd3; rt = 5'd4; rd1 = 32'h0; rd2 = 32'h9;
    mem_back = {1'b1, 32'h9, 5'd3}; use_mem_back = 1'b1; branch_type = 3'b001;
    #1;
    n_cmp++; if (branch_avail !== 1'b1) begin n_bad++; $display("FAIL branch_fwd got %b want 1", branch_avail); end
    mem_back = 38'h0; use_mem_back = 1'b0;
  endtask

  task automatic check_q(input string name, input logic [31:0] e, input logic [31:0] a1,
                         input logic [31:0] a2, input logic br);
    n_cmp++; if (q_extb !== e) begin n_bad++; $display("FAIL %s_q_extb got %h want %h", name, q_extb, e); end
    n_cmp++; if (q_rd1 !== a1) begin n_bad++; $display("FAIL %s_q_rd1 got %h want %h", name, q_rd1, a1); end
    n_cmp++; if (q_rd2 !== a2) begin n_bad++; $display("FAIL %s_q_rd2 got %h want %h", name, q_rd2, a2); end
    n_cmp++; if (q_branch !== br) begin n_bad++; $display("FAIL %s_q_branch got %b want %b", name, q_branch, br); end
  endtask

  task automatic test_reg_stage();
    @(negedge clk);
    idle_inputs();
    imm = 16'h1234; rs = 5'd1; rt = 5'd2; rd1 = 32'h5; rd2 = 32'h5; branch_type = 3'b001;
    en = 1'b1;
    @(posedge clk); #1;
    check_q("load", 32'h00001234, 32'h5, 32'h5, 1'b1);
    @(negedge clk);
    en = 1'b0; imm = 16'hFFFF; exsign = 1'b1; rd1 = 32'h3; branch_type = 3'b010;
    @(posedge clk); #1;
    check_q("hold", 32'h00001234, 32'h5, 32'h5, 1'b1);
    @(negedge clk);
    en = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    check_q("flush", 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    flush = 1'b0;
    @(posedge clk); #1;
    check_q("reload", 32'hFFFFFFFF, 32'h3, 32'h5, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_q("async_rst", 32'h0, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ext();
    test_forward();
    test_branch();
    test_branch_fwd();
    test_reg_stage();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_operand_unit.md
Name: id_operand_unit

Overview:
- Decode-stage operand block: immediate extension (EXT function), MEM/WB bypass selection for rs/rt read data (FORWARD function), and branch-condition evaluation on the forwarded operands (BRANCH function).
- Sits between the GPR read ports and the ID/EX pipeline register.
- Combinational results feed jump-PC logic in the same cycle; a registered copy feeds EX.

Parameters:
- DW, 32, data width (fixed; other values unsupported)
- RW, 5, register-index width

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset, asynchronous, active-low (rst=0 resets)
- en  in  1  register-stage load enable (0 = stall/hold)
- flush  in  1  clear register stage on next edge
- imm  in  16  instr[15:0]
- extop  in  1  0 = 16→32 extend; 1 = load-upper (imm<<16)
- exsign  in  1  when extop=0: 1 = sign-extend, 0 = zero-extend
- rs, rt  in  5 each  source register indices
- rd1, rd2  in  32 each  GPR read data
- mem_back  in  38  {regWrite, Wd[31:0], rw[4:0]} from MEM
- wb_back  in  38  same format, from WB
- use_mem_back, use_wb_back  in  1 each  bypass-source enables
- branch_type  in  3  condition select
- extb  out  32  extended immediate (combinational)
- f_rd1, f_rd2  out  32 each  forwarded operands (combinational)
- branch_avail  out  1  branch taken (combinational)
- q_extb, q_rd1, q_rd2  out  32 each  registered copies
- q_branch  out  1  registered branch_avail

Behaviour:
- Everything except the q_* outputs is purely combinational, with zero latency.
- Extension:
  - extop=1 → {imm,16'h0}.
  - extop=0, exsign=1 → {{16{imm[15]}},imm}.
  - extop=0, exsign=0 → {16'h0,imm}.
- Forwarding, for each operand (rs→f_rd1, rt→f_rd2):
  - If use_mem_back, mem regWrite=1, mem rw==index and index≠0 → mem Wd.
  - Else if use_wb_back, wb regWrite=1, wb rw==index and index≠0 → wb Wd.
  - Else → GPR data.
  - MEM has priority over WB when both match.
  - Register 0 is never forwarded.
- Branch evaluation on f_rd1/f_rd2, signed compares against zero:
  - 000 none → 0
  - 001 BEQ → rd1==rd2
  - 010 BNE → rd1!=rd2
  - 011 BGEZ → rd1≥0
  - 100 BGTZ → rd1>0
  - 101 BLEZ → rd1≤0
  - 110 BLTZ → rd1<0
  - 111 reserved → 0
- Register stage:
  - rst=0 (async) → all q_* = 0.
  - On posedge clk, flush=1 → all q_* = 0; flush has priority over en.
  - Else if en=1 → q_* load the combinational values.
  - Else → hold.
- No X propagation: all selects are fully decoded and defaults are explicit.

Decomposition:
- Shared package id_pkg holds:
  - branch_type encodings (BR_NONE..BR_LTZ)
  - bypass-bus field positions/typedef (regWrite bit 37, Wd 36:5, rw 4:0)
  - extop encodings
- One natural sub-module, operand_fwd_mux: single-operand forwarding mux, instantiated twice (rs, rt).
- Extension and branch logic stay inline.

Test Plan:
- Extension:
  - imm=16'h8001, extop=0, exsign=1 → extb=32'hFFFF8001.
  - Same with exsign=0 → 32'h00008001.
  - extop=1 → 32'h80010000.
- Forwarding, rs=5, rd1=32'h11:
  - mem_back={1,32'hAA,5}, wb_back={1,32'hBB,5} → f_rd1=32'hAA.
  - Same with use_mem_back=0 → 32'hBB.
  - Both regWrite=0 → 32'h11.
  - rs=0 with matching buses (rw=0) → rd1 passthrough.
- Branches:
  - f_rd1=f_rd2=7: BEQ → 1, BNE → 0.
  - f_rd1=32'hFFFFFFFF: BLTZ=1, BLEZ=1, BGEZ=0, BGTZ=0.
  - f_rd1=0: BGEZ=1, BLEZ=1, BGTZ=0, BLTZ=0.
  - types 000/111 → 0.
- Branch on a forwarded operand: rd1=0, rd2=9, mem forwards 9 to rs, BEQ → branch_avail=1.
- Register stage:
  - rst=0 asynchronously mid-cycle → q_* = 0 immediately.
  - After release, en=1 loads values on the edge.
  - en=0 holds them.
  - flush=1 with en=1 → q_* = 0 on the next edge.
